// File: rtl/reg_file_seq_pkg.sv
// rtl/reg_file_seq_pkg.sv - shared constants and state encoding for the register file
package reg_file_seq_pkg;

    localparam int DATA_W   = 64;
    localparam int ADDR_W   = 5;
    localparam int NUM_REGS = 32;
    localparam int ZERO_REG = 31;

    localparam logic [ADDR_W-1:0] ZERO_IDX = ADDR_W'(ZERO_REG);
    localparam logic [ADDR_W-1:0] LAST_CLR = ADDR_W'(NUM_REGS - 2);

    typedef enum logic {
        RF_INIT = 1'b0,
        RF_RUN  = 1'b1
    } rf_state_t;

endpackage

// File: rtl/reg_file_seq_if.sv
// rtl/reg_file_seq_if.sv - ALU operand/result bus between pipeline (master) and register file (slave)
interface reg_file_seq_if;
    import reg_file_seq_pkg::*;

    logic [ADDR_W-1:0] RA;
    logic [ADDR_W-1:0] RB;
    logic [ADDR_W-1:0] RW;
    logic              RegWr;
    logic [DATA_W-1:0] BusW;
    logic [DATA_W-1:0] BusA;
    logic [DATA_W-1:0] BusB;
    logic              Ready;

    modport master (
        output RA, RB, RW, RegWr, BusW,
        input  BusA, BusB, Ready
    );

    modport slave (
        input  RA, RB, RW, RegWr, BusW,
        output BusA, BusB, Ready
    );

endinterface

// File: rtl/reg_file_seq_clear.sv
// rtl/reg_file_seq_clear.sv - rf_clear_seq: INIT/RUN sequencer zeroing registers 0..NUM_REGS-2 after reset
module rf_clear_seq
    import reg_file_seq_pkg::*;
(
    input  logic              i_clk,
    input  logic              i_rst_n,
    output logic              o_ready,
    output logic              o_clr_we,
    output logic [ADDR_W-1:0] o_clr_idx
);

    rf_state_t         r_state;
    rf_state_t         w_state_nxt;
    logic [ADDR_W-1:0] r_clr_idx;
    logic [ADDR_W-1:0] w_clr_idx_nxt;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state   <= RF_INIT;
            r_clr_idx <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_clr_idx <= w_clr_idx_nxt;
        end
    end

    // The walk stops at NUM_REGS-2 so the zero register is never touched and the index never wraps.
    always_comb begin
        w_state_nxt   = r_state;
        w_clr_idx_nxt = r_clr_idx;
        o_ready       = 1'b0;
        o_clr_we      = 1'b0;
        case (r_state)
            RF_INIT: begin
                o_clr_we      = 1'b1;
                w_clr_idx_nxt = r_clr_idx + 1'b1;
                if (r_clr_idx == LAST_CLR) begin
                    w_state_nxt = RF_RUN;
                end
            end
            RF_RUN: begin
                o_ready = 1'b1;
            end
            default: begin
                w_state_nxt = RF_INIT;
            end
        endcase
    end

    assign o_clr_idx = r_clr_idx;

endmodule

// File: rtl/reg_file_seq.sv
// rtl/reg_file_seq.sv - 32x64 register file with post-reset clear sequencer; RF_BYPASS_EN enables write-through forwarding
module reg_file_seq
    import reg_file_seq_pkg::*;
(
    input  logic          Clk,
    input  logic          ResetL,
    reg_file_seq_if.slave rf
);

    logic [DATA_W-1:0] r_mem [NUM_REGS];

    logic              w_ready;
    logic              w_clr_we;
    logic [ADDR_W-1:0] w_clr_idx;
    logic              w_wr_en;
    logic [ADDR_W-1:0] w_wr_idx;
    logic [DATA_W-1:0] w_wr_data;
    logic [DATA_W-1:0] w_rd_a;
    logic [DATA_W-1:0] w_rd_b;

    rf_clear_seq u_clear (
        .i_clk     (Clk),
        .i_rst_n   (ResetL),
        .o_ready   (w_ready),
        .o_clr_we  (w_clr_we),
        .o_clr_idx (w_clr_idx)
    );

    always_comb begin
        w_wr_en   = 1'b0;
        w_wr_idx  = w_clr_idx;
        w_wr_data = '0;
        if (w_ready) begin
            w_wr_en   = rf.RegWr && (rf.RW != ZERO_IDX);
            w_wr_idx  = rf.RW;
            w_wr_data = rf.BusW;
        end else begin
            w_wr_en   = w_clr_we;
        end
    end

    // Storage has no reset; gating on ResetL drops any write coinciding with reset assertion.
    always_ff @(posedge Clk) begin
        if (ResetL && w_wr_en) begin
            r_mem[w_wr_idx] <= w_wr_data;
        end
    end

    always_comb begin
        w_rd_a = '0;
        w_rd_b = '0;
        if (w_ready) begin
            if (rf.RA != ZERO_IDX) begin
                w_rd_a = r_mem[rf.RA];
            end
            if (rf.RB != ZERO_IDX) begin
                w_rd_b = r_mem[rf.RB];
            end
        end
    end

`ifdef RF_BYPASS_EN
    logic w_fwd_ok;

    assign w_fwd_ok = w_ready && rf.RegWr && (rf.RW != ZERO_IDX);
    assign rf.BusA  = (w_fwd_ok && (rf.RA == rf.RW)) ? rf.BusW : w_rd_a;
    assign rf.BusB  = (w_fwd_ok && (rf.RB == rf.RW)) ? rf.BusW : w_rd_b;
`else
    assign rf.BusA  = w_rd_a;
    assign rf.BusB  = w_rd_b;
`endif

    assign rf.Ready = w_ready;

endmodule

// File: tb/tb_reg_file_seq.sv
// tb/tb_reg_file_seq.sv - self-checking bench: behavioural model compare plus directed literal checks
module tb_reg_file_seq;
    import reg_file_seq_pkg::*;

    logic Clk    = 1'b0;
    logic ResetL = 1'b0;

    reg_file_seq_if rf ();

    reg_file_seq dut (
        .Clk    (Clk),
        .ResetL (ResetL),
        .rf     (rf)
    );

    always #5 Clk = ~Clk;

    int errors = 0;
    int checks = 0;
    bit bypass;
    bit cmp_en = 1'b0;

    logic [63:0] m_reg [32];
    bit          m_ready;
    int          m_cnt;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: 31 clearing edges after reset release, then the file is all zeros and accepts writes.
    always @(posedge Clk or negedge ResetL) begin
        if (!ResetL) begin
            m_ready <= 1'b0;
            m_cnt   <= 0;
        end else if (!m_ready) begin
            if (m_cnt == 30) begin
                m_ready <= 1'b1;
                for (int i = 0; i < 32; i++) m_reg[i] <= 64'h0;
            end
            m_cnt <= m_cnt + 1;
        end else if (rf.RegWr && rf.RW != 5'd31) begin
            m_reg[rf.RW] <= rf.BusW;
        end
    end

    function automatic logic [63:0] m_rd(input logic [4:0] idx);
        if (!m_ready || idx == 5'd31) return 64'h0;
        if (bypass && rf.RegWr && rf.RW != 5'd31 && rf.RW == idx) return rf.BusW;
        return m_reg[idx];
    endfunction

    always @(negedge Clk) begin
        if (cmp_en) begin
            chk("cmp_ready", {63'h0, rf.Ready}, {63'h0, m_ready});
            chk("cmp_busa", rf.BusA, m_rd(rf.RA));
            chk("cmp_busb", rf.BusB, m_rd(rf.RB));
        end
    end

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic wr(input logic [4:0] idx, input logic [63:0] d);
        rf.RW    = idx;
        rf.BusW  = d;
        rf.RegWr = 1'b1;
        tick();
        rf.RegWr = 1'b0;
    endtask

    task automatic count_init(output int n);
        n = 0;
        for (int k = 0; k < 100; k++) begin
            @(negedge Clk);
            if (rf.Ready) break;
            n++;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int          n;
        logic [63:0] a, b, alu, exp_sum, d;
        logic [4:0]  ia, ib, iw;

`ifdef RF_BYPASS_EN
        bypass = 1'b1;
`else
        bypass = 1'b0;
`endif
        rf.RA    = 5'd0;
        rf.RB    = 5'd0;
        rf.RW    = 5'd2;
        rf.BusW  = 64'hBAD0_BAD0_BAD0_BAD0;
        rf.RegWr = 1'b1;
        cmp_en   = 1'b1;

        repeat (3) @(posedge Clk);
        #1;
        chk("reset_ready", {63'h0, rf.Ready}, 64'h0);
        chk("reset_busa", rf.BusA, 64'h0);
        ResetL = 1'b1;
        count_init(n);
        rf.RegWr = 1'b0;
        chk("init_cycles", 64'(n), 64'd31);
        tick();

        for (int i = 0; i < 32; i++) begin
            rf.RA = 5'(i);
            rf.RB = 5'(31 - i);
            #1;
            chk("cleared_a", rf.BusA, 64'h0);
            chk("cleared_b", rf.BusB, 64'h0);
        end

        wr(5'd5, 64'hDEADBEEF_CAFEF00D);
        wr(5'd6, 64'h1);
        rf.RA = 5'd5;
        rf.RB = 5'd6;
        #1;
        chk("x5_read", rf.BusA, 64'hDEADBEEF_CAFEF00D);
        chk("x6_read", rf.BusB, 64'h1);

        wr(5'd31, 64'hFFFF_FFFF_FFFF_FFFF);
        rf.RA = 5'd31;
        rf.RB = 5'd31;
        #1;
        chk("xzr_a", rf.BusA, 64'h0);
        chk("xzr_b", rf.BusB, 64'h0);

        wr(5'd7, 64'hAA);
        rf.RA    = 5'd7;
        rf.RB    = 5'd7;
        rf.RW    = 5'd7;
        rf.BusW  = 64'h55;
        rf.RegWr = 1'b1;
        #1;
        chk("hazard_pre", rf.BusA, bypass ? 64'h55 : 64'hAA);
        tick();
        rf.RegWr = 1'b0;
        #1;
        chk("hazard_post", rf.BusA, 64'h55);

        for (int i = 0; i < 100; i++) begin
            if (i % 2 == 0) begin
                d = {$urandom, $urandom};
                wr(5'($urandom_range(0, 31)), d);
            end else begin
                ia = 5'($urandom_range(0, 31));
                ib = 5'($urandom_range(0, 31));
                iw = 5'($urandom_range(0, 31));
                rf.RA = ia;
                rf.RB = ib;
                #1;
                alu     = rf.BusA + rf.BusB;
                a       = (ia == 5'd31) ? 64'h0 : m_reg[ia];
                b       = (ib == 5'd31) ? 64'h0 : m_reg[ib];
                exp_sum = a + b;
                chk("alu_add", alu, exp_sum);
                chk("alu_zero", {63'h0, alu == 64'h0}, {63'h0, exp_sum == 64'h0});
                wr(iw, alu);
            end
        end

        wr(5'd3, 64'h1234);
        rf.RA = 5'd3;
        #1;
        chk("x3_before_reset", rf.BusA, 64'h1234);
        @(posedge Clk);
        #3;
        ResetL = 1'b0;
        #1;
        chk("midrun_ready", {63'h0, rf.Ready}, 64'h0);
        chk("midrun_busa", rf.BusA, 64'h0);
        repeat (2) @(posedge Clk);
        #1;
        ResetL = 1'b1;
        count_init(n);
        chk("reinit_cycles", 64'(n), 64'd31);
        tick();
        rf.RA = 5'd3;
        rf.RB = 5'd5;
        #1;
        chk("x3_after_clear", rf.BusA, 64'h0);
        chk("x5_after_clear", rf.BusB, 64'h0);

        cmp_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
